// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and match helpers for the pipeline hazard controller
//
// Contents:
//   RF_AW        register-index width used by the scoreboard records
//   fwd_sel_t    Execute operand source select (regfile / W result / M ALU result)
//   mem_st_t     data-memory wait sequencer states
//   stage_rec_t  per-stage scoreboard entry {valid, rd, regwrite, load, mem}
//   writes_reg   true when a stage holds a live writer of a non-zero register r
//   fwd_pick     forwarding select for one Execute source operand
//   accesses_mem true when a stage holds a live data-memory access

package hazard_pkg;

    localparam int RF_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        WAIT = 2'b01,
        ERR  = 2'b10
    } mem_st_t;

    typedef struct packed {
        logic             valid;
        logic [RF_AW-1:0] rd;
        logic             regwrite;
        logic             load;
        logic             mem;
    } stage_rec_t;

    localparam stage_rec_t BUBBLE = '0;

    // x0 is hardwired zero, so a write to it can never create a dependency.
    function automatic logic writes_reg(input stage_rec_t rec, input logic [RF_AW-1:0] r);
        return rec.valid && rec.regwrite && (rec.rd != '0) && (rec.rd == r);
    endfunction

    // M wins over W because it holds the younger value. A load in M has no
    // data yet; the load-use stall guarantees its consumer sees it from W.
    function automatic fwd_sel_t fwd_pick(input stage_rec_t m, input stage_rec_t w,
                                          input logic [RF_AW-1:0] r);
        if (writes_reg(m, r) && !m.load) begin
            return FWD_MEM;
        end else if (writes_reg(w, r)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    function automatic logic accesses_mem(input stage_rec_t rec);
        return rec.valid && rec.mem;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - E/M/W in-flight destination tracking and dependency match
//
// Optional feature macro: HAZARD_FWD_EN (forwarding; W stage and source tracking exist only then)
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   stall_em_i           hold E and M, bubble into W
//   flush_e_i            load a bubble into E instead of the Decode instruction
//   rs1_d_i, use1_d_i    Decode source 1 and whether it is read
//   rs2_d_i, use2_d_i    Decode source 2 and whether it is read
//   d_rec_i              Decode instruction record
//   m_rec_o              current M-stage record (memory sequencer input)
//   hazard_o             Decode must stall (load-use, or any E/M RAW without forwarding)
//   fwd_a_o, fwd_b_o     Execute operand forwarding selects

module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_em_i,
    input  logic             flush_e_i,
    input  logic [RF_AW-1:0] rs1_d_i,
    input  logic             use1_d_i,
    input  logic [RF_AW-1:0] rs2_d_i,
    input  logic             use2_d_i,
    input  stage_rec_t       d_rec_i,
    output stage_rec_t       m_rec_o,
    output logic             hazard_o,
    output fwd_sel_t         fwd_a_o,
    output fwd_sel_t         fwd_b_o
);

    stage_rec_t e_q, e_d;
    stage_rec_t m_q, m_d;
    logic       e_hit;

    always_comb begin
        e_d = e_q;
        m_d = m_q;
        if (!stall_em_i) begin
            m_d = e_q;
            e_d = flush_e_i ? BUBBLE : d_rec_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            e_q <= BUBBLE;
            m_q <= BUBBLE;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
        end
    end

    assign m_rec_o = m_q;
    assign e_hit   = (use1_d_i && writes_reg(e_q, rs1_d_i)) ||
                     (use2_d_i && writes_reg(e_q, rs2_d_i));

`ifdef HAZARD_FWD_EN
    stage_rec_t       w_q, w_d;
    logic [RF_AW-1:0] rs1_e_q, rs1_e_d;
    logic [RF_AW-1:0] rs2_e_q, rs2_e_d;

    always_comb begin
        w_d     = stall_em_i ? BUBBLE : m_q;
        rs1_e_d = rs1_e_q;
        rs2_e_d = rs2_e_q;
        if (!stall_em_i) begin
            // Sources are cleared with the bubble so it never requests a forward.
            rs1_e_d = flush_e_i ? '0 : rs1_d_i;
            rs2_e_d = flush_e_i ? '0 : rs2_d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_q     <= BUBBLE;
            rs1_e_q <= '0;
            rs2_e_q <= '0;
        end else begin
            w_q     <= w_d;
            rs1_e_q <= rs1_e_d;
            rs2_e_q <= rs2_e_d;
        end
    end

    assign hazard_o = e_hit && e_q.load;
    assign fwd_a_o  = fwd_pick(m_q, w_q, rs1_e_q);
    assign fwd_b_o  = fwd_pick(m_q, w_q, rs2_e_q);
`else
    logic m_hit;

    // Without bypass paths the consumer waits until the writer reaches W,
    // where the write-first register file delivers the value.
    assign m_hit    = (use1_d_i && writes_reg(m_q, rs1_d_i)) ||
                      (use2_d_i && writes_reg(m_q, rs2_d_i));
    assign hazard_o = e_hit || m_hit;
    assign fwd_a_o  = FWD_RF;
    assign fwd_b_o  = FWD_RF;
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage RV32I pipeline sequencer: stalls, flushes, forwarding, memory wait
//
// Optional feature macro: HAZARD_FWD_EN (operand forwarding; otherwise RAW hazards stall)
//
// Parameters:
//   REG_AW       register-index width, must equal hazard_pkg::RF_AW
//   MEM_TIMEOUT  M-stage wait cycles before MemErr_o (>= 2)
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   Rs1D_i, Rs2D_i, Use1D_i, Use2D_i  Decode sources and their use flags
//   RdD_i, RegWriteD_i, LoadD_i, MemD_i  Decode destination and class
//   PCSrcE_i                      taken branch/jump resolved in Execute
//   MemAckM_i                     data memory completes the M access this cycle
//   StallF_o, StallD_o, FlushD_o, FlushE_o, StallEM_o, FlushW_o  pipeline register controls
//   ForwardAE_o, ForwardBE_o      Execute operand selects (00 RF, 01 W, 10 M)
//   MemErr_o                      sticky data-memory timeout

module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [REG_AW-1:0] Rs1D_i,
    input  logic [REG_AW-1:0] Rs2D_i,
    input  logic              Use1D_i,
    input  logic              Use2D_i,
    input  logic [REG_AW-1:0] RdD_i,
    input  logic              RegWriteD_i,
    input  logic              LoadD_i,
    input  logic              MemD_i,
    input  logic              PCSrcE_i,
    input  logic              MemAckM_i,
    output logic              StallF_o,
    output logic              StallD_o,
    output logic              FlushD_o,
    output logic              FlushE_o,
    output logic              StallEM_o,
    output logic              FlushW_o,
    output logic [1:0]        ForwardAE_o,
    output logic [1:0]        ForwardBE_o,
    output logic              MemErr_o
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    stage_rec_t      d_rec;
    stage_rec_t      m_rec;
    fwd_sel_t        fwd_a, fwd_b;
    logic            hazard;
    mem_st_t         st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mem_stall;
    logic            stall_f, stall_d, flush_d, flush_e, stall_em, flush_w;

    always_comb begin
        d_rec          = BUBBLE;
        d_rec.valid    = 1'b1;
        d_rec.rd       = RdD_i;
        d_rec.regwrite = RegWriteD_i;
        d_rec.load     = LoadD_i;
        d_rec.mem      = MemD_i;
    end

    hazard_scoreboard u_sb (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .stall_em_i (stall_em),
        .flush_e_i  (flush_e),
        .rs1_d_i    (Rs1D_i),
        .use1_d_i   (Use1D_i),
        .rs2_d_i    (Rs2D_i),
        .use2_d_i   (Use2D_i),
        .d_rec_i    (d_rec),
        .m_rec_o    (m_rec),
        .hazard_o   (hazard),
        .fwd_a_o    (fwd_a),
        .fwd_b_o    (fwd_b)
    );

    // Memory wait sequencer. The stall is combinational so an access acked
    // in the cycle it reaches M never stalls; cnt_q counts stalled cycles.
    always_comb begin
        st_d      = st_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        case (st_q)
            RUN: begin
                if (accesses_mem(m_rec) && !MemAckM_i) begin
                    mem_stall = 1'b1;
                    st_d      = WAIT;
                    cnt_d     = CW'(1);
                end
            end
            WAIT: begin
                if (MemAckM_i) begin
                    st_d  = RUN;
                    cnt_d = '0;
                end else begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                    if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
                        st_d = ERR;
                    end
                end
            end
            ERR: begin
                mem_stall = 1'b1;
            end
            default: begin
                st_d  = RUN;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q  <= RUN;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    // Priority: memory stall, then branch flush, then Decode hazard. While
    // E is frozen the branch in it is re-evaluated once it can advance.
    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        stall_em = 1'b0;
        flush_w  = 1'b0;
        if (mem_stall) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_em = 1'b1;
            flush_w  = 1'b1;
        end else if (PCSrcE_i) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (hazard) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign StallF_o    = stall_f;
    assign StallD_o    = stall_d;
    assign FlushD_o    = flush_d;
    assign FlushE_o    = flush_e;
    assign StallEM_o   = stall_em;
    assign FlushW_o    = flush_w;
    assign ForwardAE_o = fwd_a;
    assign ForwardBE_o = fwd_b;
    assign MemErr_o    = (st_q == ERR);

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl (expectations follow HAZARD_FWD_EN)

module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       mem;
    } ins_t;

    typedef struct {
        string      nm;
        logic [10:0] v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] Rs1D = '0, Rs2D = '0, RdD = '0;
    logic       Use1D = 1'b0, Use2D = 1'b0, RegWriteD = 1'b0, LoadD = 1'b0, MemD = 1'b0;
    logic       PCSrcE = 1'b0, MemAckM = 1'b0;
    logic       StallF, StallD, FlushD, FlushE, StallEM, FlushW, MemErr;
    logic [1:0] ForwardAE, ForwardBE;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .Rs1D_i      (Rs1D),
        .Rs2D_i      (Rs2D),
        .Use1D_i     (Use1D),
        .Use2D_i     (Use2D),
        .RdD_i       (RdD),
        .RegWriteD_i (RegWriteD),
        .LoadD_i     (LoadD),
        .MemD_i      (MemD),
        .PCSrcE_i    (PCSrcE),
        .MemAckM_i   (MemAckM),
        .StallF_o    (StallF),
        .StallD_o    (StallD),
        .FlushD_o    (FlushD),
        .FlushE_o    (FlushE),
        .StallEM_o   (StallEM),
        .FlushW_o    (FlushW),
        .ForwardAE_o (ForwardAE),
        .ForwardBE_o (ForwardBE),
        .MemErr_o    (MemErr)
    );

    // Expected vector layout: {StallF,StallD,FlushD,FlushE,StallEM,FlushW,FwdA,FwdB,MemErr}
    function automatic logic [10:0] ev(input logic sf, input logic sd, input logic fd,
                                       input logic fe, input logic sem, input logic fw,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic me);
        return {sf, sd, fd, fe, sem, fw, fa, fb, me};
    endfunction

    function automatic ins_t mk(input int rs1, input bit u1, input int rs2, input bit u2,
                                input int rd, input bit rw, input bit ld, input bit mem);
        ins_t i;
        i.rs1 = 5'(rs1); i.u1 = u1; i.rs2 = 5'(rs2); i.u2 = u2;
        i.rd = 5'(rd); i.rw = rw; i.ld = ld; i.mem = mem;
        return i;
    endfunction

    // Scoreboard monitor: one comparison per queued expectation, on the falling edge.
    always @(negedge clk) begin
        exp_t        x;
        logic [10:0] act;
        if (exp_q.size() > 0) begin
            x   = exp_q.pop_front();
            act = {StallF, StallD, FlushD, FlushE, StallEM, FlushW, ForwardAE, ForwardBE, MemErr};
            n_checks++;
            if (act !== x.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b (sf sd fd fe sem fw fa fb err)", x.nm, act, x.v);
            end
        end
    end

    task automatic step(input string nm, input ins_t d, input logic pc, input logic ack,
                        input logic [10:0] e);
        @(posedge clk);
        #1;
        Rs1D = d.rs1; Use1D = d.u1; Rs2D = d.rs2; Use2D = d.u2;
        RdD = d.rd; RegWriteD = d.rw; LoadD = d.ld; MemD = d.mem;
        PCSrcE = pc; MemAckM = ack;
        exp_q.push_back('{nm, e});
    endtask

    initial begin
        ins_t nop, addi1, add3, lw4, sub5, a6, add7, lw8, use8, sw2, addx0, usex0;
        logic [10:0] z, lu, br, ms, me;
        int k;

        nop   = mk(0, 0, 0, 0, 0, 0, 0, 0);
        addi1 = mk(0, 1, 0, 0, 1, 1, 0, 0);
        add3  = mk(1, 1, 2, 1, 3, 1, 0, 0);
        lw4   = mk(0, 1, 0, 0, 4, 1, 1, 1);
        sub5  = mk(4, 1, 1, 1, 5, 1, 0, 0);
        a6    = mk(0, 1, 0, 0, 6, 1, 0, 0);
        add7  = mk(0, 1, 6, 1, 7, 1, 0, 0);
        lw8   = mk(0, 1, 0, 0, 8, 1, 1, 1);
        use8  = mk(8, 1, 0, 0, 9, 1, 0, 0);
        sw2   = mk(0, 1, 2, 1, 0, 0, 0, 1);
        addx0 = mk(9, 1, 9, 1, 0, 1, 0, 0);
        usex0 = mk(0, 1, 0, 1, 10, 1, 0, 0);

        z  = ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        lu = ev(1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0);
        br = ev(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0);
        ms = ev(1, 1, 0, 0, 1, 1, 2'b00, 2'b00, 0);
        me = ev(1, 1, 0, 0, 1, 1, 2'b00, 2'b00, 1);

        step("reset", nop, 0, 0, z);
        @(negedge clk); #1; rst_n = 1'b1;

        // addi x1 ; add x3,x1,x2
        step("t1_addi_d", addi1, 0, 1, z);
`ifdef HAZARD_FWD_EN
        step("t1_add_d", add3, 0, 1, z);
        step("t1_fwdA_mem", nop, 0, 1, ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0));
`else
        step("t1_stall_e", add3, 0, 1, lu);
        step("t1_stall_m", add3, 0, 1, lu);
        step("t1_add_d", add3, 0, 1, z);
        step("t1_add_e", nop, 0, 1, z);
`endif
        for (int i = 0; i < 3; i++) step("t1_drain", nop, 0, 1, z);

        // lw x4 ; sub x5,x4,x1
        step("t2_lw_d", lw4, 0, 1, z);
        step("t2_loaduse", sub5, 0, 1, lu);
`ifdef HAZARD_FWD_EN
        step("t2_lw_m_ack", sub5, 0, 1, z);
        step("t2_fwdA_wb", nop, 0, 1, ev(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0));
`else
        step("t2_stall_m", sub5, 0, 1, lu);
        step("t2_sub_d", sub5, 0, 1, z);
        step("t2_sub_e", nop, 0, 1, z);
`endif
        for (int i = 0; i < 3; i++) step("t2_drain", nop, 0, 1, z);

        // addi x6 ; addi x6 ; add x7,x0,x6 : M result beats W result
        step("t2b_a1", a6, 0, 1, z);
        step("t2b_a2", a6, 0, 1, z);
`ifdef HAZARD_FWD_EN
        step("t2b_add_d", add7, 0, 1, z);
        step("t2b_fwdB_mem", nop, 0, 1, ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0));
`else
        step("t2b_stall_e", add7, 0, 1, lu);
        step("t2b_stall_m", add7, 0, 1, lu);
        step("t2b_add_d", add7, 0, 1, z);
        step("t2b_add_e", nop, 0, 1, z);
`endif
        for (int i = 0; i < 3; i++) step("t2b_drain", nop, 0, 1, z);

        // Taken branch with load-use also present: flush wins, no stall
        step("t3_lw_d", lw8, 0, 1, z);
        step("t3_branch", use8, 1, 1, br);
        step("t3_lw_m_ack", nop, 0, 1, z);
        for (int i = 0; i < 3; i++) step("t3_drain", nop, 0, 1, z);

        // sw in M with three unacked cycles; branch ignored while held
        step("t4_sw_d", sw2, 0, 0, z);
        step("t4_sw_e", nop, 0, 0, z);
        step("t4_wait1", nop, 0, 0, ms);
        step("t4_wait2_br", nop, 1, 0, ms);
        step("t4_wait3", nop, 0, 0, ms);
        step("t4_ack", nop, 0, 1, z);
        step("t4_after", nop, 0, 0, z);
        for (int i = 0; i < 3; i++) step("t4_drain", nop, 0, 1, z);

        // Timeout: 16 stalled cycles, then sticky error until reset
        step("t5_sw_d", sw2, 0, 0, z);
        step("t5_sw_e", nop, 0, 0, z);
        for (int i = 0; i < 16; i++) step("t5_wait", nop, 0, 0, ms);
        step("t5_err", nop, 0, 0, me);
        step("t5_err_ack", nop, 0, 1, me);
        @(negedge clk); #1; rst_n = 1'b0;
        step("t5_rst_clr", nop, 0, 0, z);
        @(negedge clk); #1; rst_n = 1'b1;
        step("t5_post_rst", nop, 0, 0, z);

        // x0 destination never creates a dependency
        step("t6_addx0_d", addx0, 0, 1, z);
        step("t6_usex0_d", usex0, 0, 1, z);
        step("t6_usex0_e", nop, 0, 1, z);
        step("t6_lwx0_d", mk(0, 1, 0, 0, 0, 1, 1, 1), 0, 1, z);
        step("t6_usex0_lu", usex0, 0, 1, z);

        k = 0;
        while (exp_q.size() > 0 && k < 10) begin
            @(posedge clk);
            k++;
        end
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
